// File: rtl/keypad_encoder.sv
// Scans a 4x3 active-low membrane keypad, debounces it and emits one key code per press.
// Optional build macro KEYPAD_REPEAT_EN adds auto-repeat strobes while a key stays held.
module keypad_encoder #(
  parameter int unsigned SCAN_DIV       = 1000,
  parameter int unsigned DEBOUNCE_SCANS = 8,
  parameter int unsigned REPEAT_SCANS   = 200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] row_i,
  output logic [2:0] col_o,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  if (SCAN_DIV < 4 || SCAN_DIV > 65535 || DEBOUNCE_SCANS < 1 || DEBOUNCE_SCANS > 255 ||
      REPEAT_SCANS < 1 || REPEAT_SCANS > 65535) begin : g_param_check
    $error("keypad_encoder: parameter out of legal range");
  end

  typedef enum logic [1:0] {SCAN, DEBOUNCE, ACCEPT, HOLD} state_e;

  localparam logic [15:0] TICK_LAST = 16'(SCAN_DIV - 1);
  localparam logic [7:0]  DEB_DONE  = 8'(DEBOUNCE_SCANS);

  state_e      state_q, state_d;
  logic [3:0]  row_s1_q, row_s2_q;
  logic [15:0] tick_cnt_q, tick_cnt_d;
  logic [1:0]  col_q, col_d;
  logic [1:0]  row_idx_q, row_idx_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [3:0]  code_q, code_d;
  logic        valid_q, valid_d;
  logic        held_q, held_d;
  logic        tick, single, go_accept;
  logic [1:0]  idx, col_nxt;
  logic [7:0]  cnt_inc;
`ifdef KEYPAD_REPEAT_EN
  localparam logic [15:0] REP_DONE = 16'(REPEAT_SCANS);
  logic [15:0] rep_cnt_q, rep_cnt_d;
`endif

  function automatic logic [3:0] map_code(input logic [1:0] row, input logic [1:0] col);
    logic [3:0] code;
    code = 4'(row) * 4'd3 + 4'(col) + 4'd1;
    if (row == 2'd3) begin
      case (col)
        2'd0:    code = 4'b1010;
        2'd1:    code = 4'h0;
        default: code = 4'b1011;
      endcase
    end
    return code;
  endfunction

  assign tick    = (tick_cnt_q == TICK_LAST);
  assign col_nxt = (col_q == 2'd2) ? 2'd0 : col_q + 2'd1;
  assign cnt_inc = cnt_q + 8'd1;

  always_comb begin
    single = 1'b1;
    idx    = '0;
    case (row_s2_q)
      4'b1110: idx = 2'd0;
      4'b1101: idx = 2'd1;
      4'b1011: idx = 2'd2;
      4'b0111: idx = 2'd3;
      default: single = 1'b0;
    endcase
  end

  always_comb begin
    col_o = 3'b110;
    case (col_q)
      2'd1:    col_o = 3'b101;
      2'd2:    col_o = 3'b011;
      default: col_o = 3'b110;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick ? '0 : tick_cnt_q + 16'd1;
    col_d      = col_q;
    row_idx_d  = row_idx_q;
    cnt_d      = cnt_q;
    code_d     = code_q;
    valid_d    = 1'b0;
    held_d     = held_q;
    go_accept  = 1'b0;
`ifdef KEYPAD_REPEAT_EN
    rep_cnt_d  = '0;
`endif
    case (state_q)
      SCAN: if (tick) begin
        if (single) begin
          row_idx_d = idx;
          cnt_d     = 8'd1;
          if (DEB_DONE == 8'd1) go_accept = 1'b1;
          else                  state_d   = DEBOUNCE;
        end else begin
          col_d = col_nxt;
        end
      end
      DEBOUNCE: if (tick) begin
        if (single && idx == row_idx_q) begin
          cnt_d = cnt_inc;
          if (cnt_inc == DEB_DONE) go_accept = 1'b1;
        end else begin
          cnt_d   = '0;
          col_d   = col_nxt;
          state_d = SCAN;
        end
      end
      ACCEPT: begin
        cnt_d   = '0;
        state_d = HOLD;
      end
      default: begin
`ifdef KEYPAD_REPEAT_EN
        rep_cnt_d = rep_cnt_q;
        if (tick) begin
          if (single && idx == row_idx_q) begin
            rep_cnt_d = rep_cnt_q + 16'd1;
            if (rep_cnt_q + 16'd1 == REP_DONE) begin
              rep_cnt_d = '0;
              valid_d   = 1'b1;
            end
          end else begin
            rep_cnt_d = '0;
          end
        end
`endif
        if (tick) begin
          if (row_s2_q == 4'hF) begin
            cnt_d = cnt_inc;
            if (cnt_inc == DEB_DONE) begin
              cnt_d   = '0;
              held_d  = 1'b0;
              col_d   = col_nxt;
              state_d = SCAN;
            end
          end else begin
            cnt_d = '0;
          end
        end
      end
    endcase
    // Strobe and code are registered on entry so both are visible during ACCEPT.
    if (go_accept) begin
      state_d = ACCEPT;
      code_d  = map_code(idx, col_q);
      valid_d = 1'b1;
      held_d  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= SCAN;
      row_s1_q   <= '1;
      row_s2_q   <= '1;
      tick_cnt_q <= '0;
      col_q      <= '0;
      row_idx_q  <= '0;
      cnt_q      <= '0;
      code_q     <= '0;
      valid_q    <= 1'b0;
      held_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      row_s1_q   <= row_i;
      row_s2_q   <= row_s1_q;
      tick_cnt_q <= tick_cnt_d;
      col_q      <= col_d;
      row_idx_q  <= row_idx_d;
      cnt_q      <= cnt_d;
      code_q     <= code_d;
      valid_q    <= valid_d;
      held_q     <= held_d;
    end
  end

`ifdef KEYPAD_REPEAT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rep_cnt_q <= '0;
    else        rep_cnt_q <= rep_cnt_d;
  end
`endif

  assign key_code  = code_q;
  assign key_valid = valid_q;
  assign key_held  = held_q;

endmodule

// File: tb/tb_keypad_encoder.sv
// Directed bench for keypad_encoder: a board-level keypad model drives rows from the column strobes.
module tb_keypad_encoder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] row_i;
  logic [2:0] col_o;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;

  logic [3:0][2:0] pressed;
  int   n_assert = 0;
  int   n_fail   = 0;
  int   vcnt     = 0;
  logic [3:0] vcode = '0;
  int   base;
  logic [2:0] seen;
  logic       legal;
  bit         got;

`ifdef KEYPAD_REPEAT_EN
  localparam int REP_PULSES = 4;
`else
  localparam int REP_PULSES = 1;
`endif

  keypad_encoder #(.SCAN_DIV(4), .DEBOUNCE_SCANS(8), .REPEAT_SCANS(20)) dut (
    .clk(clk), .rst_n(rst_n), .row_i(row_i), .col_o(col_o),
    .key_code(key_code), .key_valid(key_valid), .key_held(key_held)
  );

  always #5 clk = ~clk;

  always_comb begin
    for (int r = 0; r < 4; r++) row_i[r] = ~|(pressed[r] & ~col_o);
  end

  always @(negedge clk) begin
    if (rst_n && key_valid) begin
      vcnt  <= vcnt + 1;
      vcode <= key_code;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clocks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic watch_cols(input int n);
    seen  = '0;
    legal = 1'b1;
    repeat (n) begin
      @(posedge clk); #1;
      case (col_o)
        3'b110:  seen[0] = 1'b1;
        3'b101:  seen[1] = 1'b1;
        3'b011:  seen[2] = 1'b1;
        default: legal = 1'b0;
      endcase
    end
  endtask

  initial begin
    rst_n   = 1'b0;
    pressed = '0;
    clocks(3);
    check("reset_col", 32'(col_o), 32'h6);
    check("reset_code", 32'(key_code), 32'h0);
    check("reset_valid", 32'(key_valid), 32'h0);
    check("reset_held", 32'(key_held), 32'h0);
    rst_n = 1'b1;

    watch_cols(16);
    check("idle_rotate_seen", 32'(seen), 32'h7);
    check("idle_rotate_legal", 32'(legal), 32'h1);

    // key 3: row 0, column 2
    base = vcnt;
    pressed[0][2] = 1'b1;
    clocks(64);
    check("key3_pulses", 32'(vcnt - base), 32'd1);
    check("key3_code", 32'(vcode), 32'h3);
    check("key3_held", 32'(key_held), 32'h1);

    // reset while the key is held
    rst_n = 1'b0;
    #1;
    check("midrst_col", 32'(col_o), 32'h6);
    check("midrst_valid", 32'(key_valid), 32'h0);
    check("midrst_held", 32'(key_held), 32'h0);
    check("midrst_code", 32'(key_code), 32'h0);
    pressed = '0;
    clocks(3);
    rst_n = 1'b1;
    clocks(4);

    // star then hash
    base = vcnt;
    pressed[3][0] = 1'b1;
    clocks(64);
    check("star_pulses", 32'(vcnt - base), 32'd1);
    check("star_code", 32'(vcode), 32'hA);
    check("star_held", 32'(key_held), 32'h1);
    pressed = '0;
    clocks(44);
    check("star_release", 32'(key_held), 32'h0);
    base = vcnt;
    pressed[3][2] = 1'b1;
    clocks(64);
    check("hash_pulses", 32'(vcnt - base), 32'd1);
    check("hash_code", 32'(vcode), 32'hB);
    pressed = '0;
    clocks(44);
    check("hash_release", 32'(key_held), 32'h0);

    // bouncing key 5, then stable
    base = vcnt;
    for (int i = 0; i < 6; i++) begin
      pressed[1][1] = (i % 2 == 0);
      clocks(4);
    end
    check("bounce_no_pulse", 32'(vcnt - base), 32'd0);
    pressed[1][1] = 1'b1;
    clocks(64);
    check("key5_pulses", 32'(vcnt - base), 32'd1);
    check("key5_code", 32'(vcode), 32'h5);
    pressed = '0;
    clocks(44);
    check("key5_release", 32'(key_held), 32'h0);

    // ghost: two rows low in column 1
    base = vcnt;
    pressed[0][1] = 1'b1;
    pressed[1][1] = 1'b1;
    clocks(64);
    check("ghost_no_pulse", 32'(vcnt - base), 32'd0);
    watch_cols(16);
    check("ghost_rotate_seen", 32'(seen), 32'h7);
    check("ghost_held", 32'(key_held), 32'h0);
    pressed = '0;
    clocks(8);

    // key 0 held, key 8 added in HOLD
    base = vcnt;
    pressed[3][1] = 1'b1;
    clocks(64);
    check("key0_pulses", 32'(vcnt - base), 32'd1);
    check("key0_code", 32'(vcode), 32'h0);
    check("key0_held", 32'(key_held), 32'h1);
    pressed[2][1] = 1'b1;
    clocks(64);
    check("second_key_ignored", 32'(vcnt - base), 32'd1);
    check("second_key_held", 32'(key_held), 32'h1);
    pressed = '0;
    clocks(44);
    check("key0_release", 32'(key_held), 32'h0);

    // key 7 held for 70 ticks after acceptance
    base = vcnt;
    pressed[2][0] = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(posedge clk); #1;
      if (key_valid) got = 1'b1;
    end
    check("key7_accept_seen", 32'(got), 32'h1);
    clocks(280);
    check("key7_pulses", 32'(vcnt - base), 32'(REP_PULSES));
    check("key7_code", 32'(vcode), 32'h7);
    check("key7_held", 32'(key_held), 32'h1);
    pressed = '0;
    clocks(44);
    check("key7_release", 32'(key_held), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
